// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch queue block.
package cpu_pkg;

  localparam int DataWidth  = 32;
  localparam int AddrWidth  = 32;
  localparam int InstrBytes = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WAIT_DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    logic [DataWidth-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Small circular FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module cpu_fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  Depth   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PtrW    = $clog2(Depth),
  localparam int CntW    = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  entry_t          data_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o
);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Popping an empty FIFO is ignored so the count cannot underflow.
  assign do_push = push_i;
  assign do_pop  = pop_i && (count_q != '0);

  // Next-state pointers and count; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cpu_fetch_queue.sv
// Fetch sequencer plus prefetch queue: issues one PC at a time, queues the
// returned instructions and hands them to decode; redirects flush everything.
module cpu_fetch_queue
  import cpu_pkg::*;
#(
  parameter int                   Depth   = 4,
  parameter logic [AddrWidth-1:0] ResetPc = 32'h0000_0000,
  localparam int                  LevelW  = $clog2(Depth + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [AddrWidth-1:0] redirect_pc,
  output logic                 pc_valid,
  output logic [AddrWidth-1:0] pc,
  input  logic [DataWidth-1:0] instr,
  input  logic                 instr_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_instr,
  output logic [AddrWidth-1:0] out_pc,
  output logic [LevelW-1:0]    level
);

  fetch_state_t         state_q, state_d;
  logic [AddrWidth-1:0] pc_q, pc_d;
  logic                 pc_valid_q, pc_valid_d;
  // Set by reset, cleared by the first issue: a request abandoned by reset
  // may still answer, so a response in IDLE is tolerated until then.
  logic                 rst_stale_q, rst_stale_d;
  logic                 issue, push, flush;
  logic [LevelW-1:0]    count;
  fetch_entry_t         push_entry, head;

  // Issuing reserves a FIFO slot, so the single outstanding response always fits.
  assign issue = (state_q == IDLE) && fetch_en && (count < LevelW'(Depth)) && !redirect_valid;

  // Next-state, PC and push/flush decode; redirect overrides everything else.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = 1'b0;
    rst_stale_d = rst_stale_q;
    push        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d     = WAIT;
          pc_valid_d  = 1'b1;
          rst_stale_d = 1'b0;
        end
      end
      WAIT: begin
        if (instr_valid) begin
          state_d = IDLE;
          if (!redirect_valid) begin
            push = 1'b1;
            pc_d = pc_q + AddrWidth'(InstrBytes);
          end
        end else if (redirect_valid) begin
          state_d = WAIT_DISCARD;
        end
      end
      WAIT_DISCARD: begin
        // The stale response ends the discard even if another redirect
        // lands in the same cycle; otherwise nothing would ever release it.
        if (instr_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = {redirect_pc[AddrWidth-1:2], 2'b00};
    end
  end

  // Sequencer state, fetch PC and the one-cycle request strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= ResetPc;
      pc_valid_q  <= 1'b0;
      rst_stale_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      rst_stale_q <= rst_stale_d;
    end
  end

  assign push_entry = '{pc: pc_q, instr: instr};

  cpu_fetch_fifo #(
    .Depth   (Depth),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (out_valid && out_ready),
    .flush_i (flush),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign level     = count;

  // A response with no request outstanding is a fetch-stage protocol error.
  a_no_resp_in_idle : assert property (@(posedge clk) disable iff (!reset_n)
    !((state_q == IDLE) && instr_valid && !rst_stale_q))
    else $error("instr_valid while IDLE with no request outstanding");

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench: a behavioural fetch stage answers each pc_valid, a
// scoreboard checks decode-side output order, and directed sequences cover
// full queue, redirects, address wrap and reset mid-request.
module tb_cpu_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n, fetch_en, redirect_valid, pc_valid, instr_valid;
  logic        out_valid, out_ready;
  logic [31:0] redirect_pc, pc, instr, out_instr, out_pc;
  logic [2:0]  level;

  localparam logic [31:0] Key = 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  cpu_fetch_queue #(.Depth(4), .ResetPc(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .level          (level)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    int          nresp;
  } redir_vec_t;

  exp_t        exp_q[$];
  logic [31:0] issued[$];
  int          checks = 0;
  int          passes = 0;
  bit          resp_en = 1'b1;
  int          resp_lat = 1;
  bit          chk_outst = 1'b0;
  bit          outst = 1'b0;
  logic [31:0] rp;
  int          rl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = p ^ Key;
    exp_q.push_back(e);
  endtask

  task automatic wait_issued(input int n);
    int k;
    for (k = 0; k < 200 && issued.size() < n; k++) tick();
    if (issued.size() < n) begin
      checks++;
      $display("FAIL wait_issued: got %0d pc_valid pulses expected %0d", issued.size(), n);
    end
  endtask

  task automatic wait_level(input int n);
    int k;
    for (k = 0; k < 200 && int'(level) != n; k++) tick();
    if (int'(level) != n) begin
      checks++;
      $display("FAIL wait_level: got %0d expected %0d", level, n);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    outst   = 1'b0;
    tick();
    issued.delete();
  endtask

  // Behavioural fetch stage: answers each request resp_lat cycles later.
  always begin
    @(negedge clk);
    if (reset_n && pc_valid && resp_en) begin
      rp = pc;
      rl = resp_lat;
      repeat (rl - 1) @(negedge clk);
      @(posedge clk);
      #1;
      instr       = rp ^ Key;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
  end

  // Issue log, outstanding-request check and decode-side scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (pc_valid) begin
        if (chk_outst) chk("one_outstanding", 32'(outst), 32'd0);
        outst = 1'b1;
        issued.push_back(pc);
      end
      if (instr_valid) outst = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: got pc %h with no expected entry", out_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_pc", out_pc, e.pc);
          chk("sb_instr", out_instr, e.instr);
        end
      end
    end
  end

  redir_vec_t vecs[4];

  initial begin
    vecs[0] = '{rpc: 32'h0000_0103, exp_pc: 32'h0000_0100, nresp: 2};
    vecs[1] = '{rpc: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8, nresp: 2};
    vecs[2] = '{rpc: 32'h0000_0007, exp_pc: 32'h0000_0004, nresp: 1};
    vecs[3] = '{rpc: 32'hABCD_EF02, exp_pc: 32'hABCD_EF00, nresp: 3};

    reset_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_valid = 1'b0; instr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pc_valid", 32'(pc_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pc", pc, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Streaming fetch with decode always ready.
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    chk_outst = 1'b1; out_ready = 1'b1; fetch_en = 1'b1;
    wait_issued(4);
    fetch_en = 1'b0;
    repeat (10) tick();
    chk_outst = 1'b0;
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("stream_issue_pc", issued[i], 32'(i * 4));
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("stream_level", 32'(level), 32'd0);

    // Fill to full with decode stalled, then release one slot.
    do_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    wait_level(4);
    repeat (8) tick();
    @(negedge clk);
    chk("full_level", 32'(level), 32'd4);
    chk("full_issues", 32'(issued.size()), 32'd4);
    chk("full_pc_valid", 32'(pc_valid), 32'd0);
    tick();
    push_exp(32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("pop_one_level", 32'(level), 32'd3);
    wait_issued(5);
    fetch_en = 1'b0;
    if (issued.size() >= 5) chk("refill_pc", issued[4], 32'h10);
    repeat (5) tick();
    chk("refill_level", 32'(level), 32'd4);
    for (int i = 1; i <= 4; i++) push_exp(32'(i * 4));
    out_ready = 1'b1;
    repeat (8) tick();
    chk("full_drain_level", 32'(level), 32'd0);
    chk("full_drained", 32'(exp_q.size()), 32'd0);

    // Redirect while waiting; response arrives three cycles later and is dropped.
    do_reset();
    out_ready = 1'b1; resp_lat = 4; fetch_en = 1'b1;
    wait_issued(1);
    push_exp(32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0; resp_lat = 1;
    @(negedge clk);
    chk("rdw_level", 32'(level), 32'd0);
    chk("rdw_out_valid", 32'(out_valid), 32'd0);
    wait_issued(2);
    fetch_en = 1'b0;
    if (issued.size() >= 2) chk("rdw_next_pc", issued[1], 32'h100);
    repeat (6) tick();
    chk("rdw_drained", 32'(exp_q.size()), 32'd0);
    chk("rdw_level_end", 32'(level), 32'd0);

    // Redirect coincident with the response, two entries queued.
    do_reset();
    out_ready = 1'b0; fetch_en = 1'b1;
    wait_issued(2);
    resp_en = 1'b0;
    wait_issued(3);
    chk("rdr_level_before", 32'(level), 32'd2);
    instr = 32'hDEAD_BEEF; instr_valid = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    instr_valid = 1'b0; redirect_valid = 1'b0; resp_en = 1'b1;
    @(negedge clk);
    chk("rdr_level_after", 32'(level), 32'd0);
    wait_issued(4);
    fetch_en = 1'b0;
    if (issued.size() >= 4) chk("rdr_next_pc", issued[3], 32'h200);
    push_exp(32'h200);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rdr_drained", 32'(exp_q.size()), 32'd0);

    // Table of redirect targets from IDLE, including alignment and wrap.
    out_ready = 1'b1; fetch_en = 1'b0;
    foreach (vecs[v]) begin
      issued.delete();
      redirect_valid = 1'b1; redirect_pc = vecs[v].rpc;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i <= vecs[v].nresp; i++) push_exp(vecs[v].exp_pc + 32'(4 * i));
      fetch_en = 1'b1;
      wait_issued(vecs[v].nresp + 1);
      fetch_en = 1'b0;
      repeat (6) tick();
      for (int i = 0; i <= vecs[v].nresp && i < issued.size(); i++)
        chk("tbl_issue_pc", issued[i], vecs[v].exp_pc + 32'(4 * i));
      chk("tbl_drained", 32'(exp_q.size()), 32'd0);
    end

    // Reset while a request is outstanding; stale responses must not push.
    resp_en = 1'b0; out_ready = 1'b0; fetch_en = 1'b1;
    issued.delete();
    wait_issued(1);
    reset_n = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    chk("rsw_pc", pc, 32'h0);
    chk("rsw_pc_valid", 32'(pc_valid), 32'd0);
    tick();
    instr = 32'h1234_5678; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    reset_n = 1'b1;
    outst = 1'b0;
    tick();
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("rsw_level", 32'(level), 32'd0);
    chk("rsw_out_valid", 32'(out_valid), 32'd0);
    tick();
    resp_en = 1'b1; out_ready = 1'b1;
    issued.delete();
    push_exp(32'h0);
    fetch_en = 1'b1;
    wait_issued(1);
    fetch_en = 1'b0;
    if (issued.size() >= 1) chk("rsw_first_pc", issued[0], 32'h0);
    repeat (6) tick();
    chk("rsw_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_queue.md
Name: cpu_fetch_queue

Overview:
- Instruction sequencer and prefetch buffer that sits directly upstream and downstream of cpu_fetch (instruction fetch stage).
- Generates the fetch PC and a one-cycle pc_valid request into the fetch stage, and captures each returned instr/instr_valid tagged with its PC into a small FIFO.
- Presents queued instructions to decode over a valid/ready handshake.
- Handles control-flow redirects: flushes the queue and discards the in-flight response.

Parameters:
- DataWidth, 32, instruction width (localparam in package; fixed).
- AddrWidth, 32, PC width (fixed).
- Depth, 4, FIFO entries; power of two, >= 2.
- ResetPc, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  allow new fetch requests.
- redirect_valid  in  1  one-cycle redirect strobe from execute.
- redirect_pc  in  AddrWidth  redirect target; bits [1:0] ignored (forced 0).
- pc_valid  out  1  one-cycle fetch request to the fetch stage.
- pc  out  AddrWidth  fetch address; held stable from issue until response.
- instr  in  DataWidth  instruction word from the fetch stage.
- instr_valid  in  1  response strobe from the fetch stage, one cycle per request.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  DataWidth  head instruction.
- out_pc  out  AddrWidth  PC of head instruction.
- level  out  $clog2(Depth+1)  current occupancy.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=ResetPc, pc_valid=0, count=0, out_valid=0, level=0. A reset mid-request abandons it; any later instr_valid is ignored until a new issue.
- Only one request is outstanding at a time.
- State IDLE:
  - Issue when fetch_en && count<Depth && !redirect_valid.
  - On issue, pc_valid=1 in the next cycle (registered) for exactly one cycle, then go to WAIT.
- State WAIT, on instr_valid:
  - Push {pc, instr}.
  - pc <= pc+4 (modulo 2^AddrWidth; 32'hFFFF_FFFC wraps to 0).
  - Go to IDLE. Earliest reissue is the cycle after the response.
- State WAIT_DISCARD, on instr_valid: drop the response, go to IDLE, no push.
- instr_valid in IDLE is ignored; it is a protocol error, and a simulation assertion fires.
- Redirect has priority over push, pop and issue. It acts in any state:
  - count <= 0; pc <= {redirect_pc[AddrWidth-1:2], 2'b00}.
  - In WAIT without instr_valid the same cycle: go to WAIT_DISCARD.
  - In WAIT with instr_valid the same cycle: drop the response, go to IDLE.
  - In WAIT_DISCARD: stay in WAIT_DISCARD.
  - In IDLE: no issue that cycle.
  - out_valid is 0 from the cycle after the redirect.
- Issue reserves space. count<Depth at issue, so a response always fits. No overflow is possible.
- Output side:
  - out_valid = (count!=0).
  - out_instr and out_pc come combinationally from the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged, including at count==Depth-1 and when count==1.
- fetch_en low:
  - No new issue.
  - An outstanding request still completes and pushes.
- level equals count.

Decomposition:
- cpu_pkg: fetch_state_t enum {IDLE, WAIT, WAIT_DISCARD}, InstrBytes=4, fetch_entry_t struct {pc, instr}.
- Sub-module cpu_fetch_fifo (Depth, fetch_entry_t):
  - Inputs: push, pop, flush.
  - Outputs: head, count.
  - Flush has priority over push and pop.
  - Pointers wrap modulo Depth.

Test Plan:
- Reset, fetch_en=1, out_ready=1, instr_valid one cycle after each pc_valid with instr=pc^32'hA5A5_A5A5 -> pc_valid sequence 0,4,8,C; out_pc/out_instr match in order; never more than one outstanding.
- out_ready=0, responses always returned -> exactly 4 pushes; level=4; pc_valid stays 0 while full. Then out_ready=1 for one cycle -> level=3 and a new issue of pc=0x10 the following cycle.
- Redirect to 0x103 while in WAIT, fetch response arrives 3 cycles later -> response discarded; level=0; next pc_valid with pc=0x100; first out_pc=0x100.
- redirect_valid in the same cycle as instr_valid, with level=2 -> no push; level=0 next cycle; next issue pc=redirect target.
- Redirect at pc=0xFFFF_FFF8, two responses -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, then next pc_valid at pc=0x0.
- reset_n asserted while in WAIT, instr_valid pulsed during reset and after release -> no push; state IDLE; first post-reset pc_valid at ResetPc.
